// File: rtl/sisc_ifetch_if.sv
// Instruction-memory read bus between the SISC fetch unit and instruction memory.
// The fetch unit is the master: it drives the address and request and waits for ack.
interface sisc_ifetch_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_req;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/sisc_ifetch.sv
// SISC instruction-fetch unit: PC, instruction register, req/ack fetch from
// instruction memory, absolute/relative branch loading and HLT detection.
module sisc_ifetch #(
    parameter int                 ADDR_W   = 16,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_f,
    input  logic                 fetch_req,
    input  logic                 pc_write,
    input  logic                 br_rel,
    sisc_ifetch_if.master        imem,
    output logic [INSTR_W-1:0]   ir,
    output logic [3:0]           opcode,
    output logic [3:0]           mm,
    output logic                 ir_valid,
    output logic [ADDR_W-1:0]    pc_out,
    output logic                 busy,
    output logic                 halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   pc_nx, addr_nx, pc_upd;
    logic [INSTR_W-1:0]  ir_nx;
    logic                req_nx, valid_nx, busy_nx, halted_nx;
    logic                pend, pend_nx, pend_rel, pend_rel_nx;

    // The branch offset is a signed field; addition wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] br_target(
        input logic [ADDR_W-1:0]        pc_cur,
        input logic signed [ADDR_W-1:0] off,
        input logic                     rel
    );
        return rel ? (pc_cur + $unsigned(off)) : $unsigned(off);
    endfunction

    assign opcode = ir[INSTR_W-1 -: 4];
    assign mm     = ir[INSTR_W-5 -: 4];

    always_comb begin
        state_nx    = state;
        pc_nx       = pc_out;
        addr_nx     = imem.imem_addr;
        ir_nx       = ir;
        req_nx      = imem.imem_req;
        valid_nx    = ir_valid;
        busy_nx     = busy;
        halted_nx   = halted;
        pend_nx     = pend;
        pend_rel_nx = pend_rel;
        pc_upd      = pc_out;

        unique case (state)
            ST_IDLE: begin
                // A branch deferred from the previous fetch takes priority over a new pc_write.
                if (pend) begin
                    pc_upd  = br_target(pc_out, ir[ADDR_W-1:0], pend_rel);
                    pend_nx = 1'b0;
                end else if (pc_write) begin
                    pc_upd = br_target(pc_out, ir[ADDR_W-1:0], br_rel);
                end
                pc_nx = pc_upd;
                if (fetch_req) begin
                    state_nx = ST_REQ;
                    req_nx   = 1'b1;
                    addr_nx  = pc_upd;
                    valid_nx = 1'b0;
                    busy_nx  = 1'b1;
                end else begin
                    busy_nx = 1'b0;
                end
            end
            ST_REQ: begin
                if (pc_write) begin
                    pend_nx     = 1'b1;
                    pend_rel_nx = br_rel;
                end
                if (imem.imem_ack) begin
                    ir_nx    = imem.imem_rdata;
                    pc_nx    = pc_out + 1'b1;
                    req_nx   = 1'b0;
                    valid_nx = 1'b1;
                    if (imem.imem_rdata[INSTR_W-1 -: 4] == 4'hF) begin
                        state_nx  = ST_HALT;
                        halted_nx = 1'b1;
                        busy_nx   = 1'b1;
                        pend_nx   = 1'b0;
                    end else begin
                        // Stay busy one more cycle while a deferred branch is applied.
                        state_nx = ST_IDLE;
                        busy_nx  = pend_nx;
                    end
                end
            end
            ST_HALT: begin
                valid_nx  = 1'b1;
                halted_nx = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state          <= ST_IDLE;
            pc_out         <= RESET_PC;
            imem.imem_addr <= RESET_PC;
            imem.imem_req  <= 1'b0;
            ir             <= '0;
            ir_valid       <= 1'b0;
            busy           <= 1'b0;
            halted         <= 1'b0;
            pend           <= 1'b0;
            pend_rel       <= 1'b0;
        end else begin
            state          <= state_nx;
            pc_out         <= pc_nx;
            imem.imem_addr <= addr_nx;
            imem.imem_req  <= req_nx;
            ir             <= ir_nx;
            ir_valid       <= valid_nx;
            busy           <= busy_nx;
            halted         <= halted_nx;
            pend           <= pend_nx;
            pend_rel       <= pend_rel_nx;
        end
    end

endmodule

// File: tb/tb_sisc_ifetch.sv
// Directed bench for sisc_ifetch: fetch latency, wait states, branches,
// PC wrap, deferred branch during fetch, halt and reset abort.
module tb_sisc_ifetch;

    logic        clk = 1'b0;
    logic        rst_f, fetch_req, pc_write, br_rel;
    logic [31:0] ir;
    logic [3:0]  opcode, mm;
    logic        ir_valid, busy, halted;
    logic [15:0] pc_out;
    int          checks = 0;
    int          errors = 0;

    sisc_ifetch_if #(.ADDR_W(16), .INSTR_W(32)) bus ();

    sisc_ifetch #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .fetch_req (fetch_req),
        .pc_write  (pc_write),
        .br_rel    (br_rel),
        .imem      (bus),
        .ir        (ir),
        .opcode    (opcode),
        .mm        (mm),
        .ir_valid  (ir_valid),
        .pc_out    (pc_out),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] data, input int wait_cycles);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        repeat (wait_cycles) tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data;
        tick();
        bus.imem_ack   = 1'b0;
    endtask

    task automatic branch(input logic rel);
        pc_write = 1'b1;
        br_rel   = rel;
        tick();
        pc_write = 1'b0;
        br_rel   = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},    32'(pc_out), 32'h0);
        chk({tag, "_ir"},    ir, 32'h0);
        chk({tag, "_vld"},   32'(ir_valid), 32'h0);
        chk({tag, "_req"},   32'(bus.imem_req), 32'h0);
        chk({tag, "_addr"},  32'(bus.imem_addr), 32'h0);
        chk({tag, "_busy"},  32'(busy), 32'h0);
        chk({tag, "_halt"},  32'(halted), 32'h0);
    endtask

    initial begin
        rst_f = 1'b1; fetch_req = 1'b0; pc_write = 1'b0; br_rel = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        tick(); tick();
        rst_f = 1'b0;
        chk_reset("rst");

        // Zero-wait fetch
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("t1_req", 32'(bus.imem_req), 32'h1);
        chk("t1_addr", 32'(bus.imem_addr), 32'h0);
        chk("t1_vld0", 32'(ir_valid), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1100_0005;
        tick();
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'hDEAD_BEEF;
        chk("t1_vld1", 32'(ir_valid), 32'h1);
        chk("t1_ir", ir, 32'h1100_0005);
        chk("t1_op", 32'(opcode), 32'h1);
        chk("t1_mm", 32'(mm), 32'h1);
        chk("t1_pc", 32'(pc_out), 32'h1);
        chk("t1_req0", 32'(bus.imem_req), 32'h0);
        chk("t1_busy0", 32'(busy), 32'h0);

        // Three wait states: request and address held, ir untouched until ack
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_req", 32'(bus.imem_req), 32'h1);
            chk("t2_addr", 32'(bus.imem_addr), 32'h1);
            chk("t2_ir", ir, 32'h1100_0005);
            tick();
        end
        chk("t2_req4", 32'(bus.imem_req), 32'h1);
        chk("t2_addr4", 32'(bus.imem_addr), 32'h1);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2200_0000;
        tick();
        bus.imem_ack = 1'b0;
        chk("t2_ir_ack", ir, 32'h2200_0000);
        chk("t2_pc", 32'(pc_out), 32'h2);

        // Relative and absolute branches from IDLE
        fetch(32'h4000_000F, 0);
        branch(1'b0);
        chk("t3_pc_f", 32'(pc_out), 32'h000F);
        fetch(32'h5000_FFFE, 0);
        chk("t3_pc_10", 32'(pc_out), 32'h0010);
        branch(1'b1);
        chk("t3_brr", 32'(pc_out), 32'h000E);
        fetch(32'h4000_0020, 1);
        branch(1'b0);
        chk("t3_bra", 32'(pc_out), 32'h0020);

        // PC wrap-around
        fetch(32'h4000_FFFF, 0);
        branch(1'b0);
        chk("t4_pc_max", 32'(pc_out), 32'hFFFF);
        fetch(32'h1000_0000, 0);
        chk("t4_addr", 32'(bus.imem_addr), 32'hFFFF);
        chk("t4_wrap", 32'(pc_out), 32'h0000);

        // pc_write and fetch_req together: new PC is fetched
        fetch(32'h4000_0030, 0);
        pc_write = 1'b1; br_rel = 1'b0; fetch_req = 1'b1;
        tick();
        pc_write = 1'b0; fetch_req = 1'b0;
        chk("t4b_addr", 32'(bus.imem_addr), 32'h0030);
        chk("t4b_pc", 32'(pc_out), 32'h0030);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1000_0000;
        tick();
        bus.imem_ack = 1'b0;
        chk("t4b_pc1", 32'(pc_out), 32'h0031);

        // Branch requested mid-fetch uses the newly fetched ir
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        pc_write = 1'b1; br_rel = 1'b1;
        tick();
        pc_write = 1'b0; br_rel = 1'b0;
        chk("t5_pc_hold", 32'(pc_out), 32'h0031);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h5000_0010;
        tick();
        bus.imem_ack = 1'b0;
        chk("t5_pc_inc", 32'(pc_out), 32'h0032);
        chk("t5_busy", 32'(busy), 32'h1);
        chk("t5_vld", 32'(ir_valid), 32'h1);
        tick();
        chk("t5_pc_br", 32'(pc_out), 32'h0042);
        chk("t5_busy0", 32'(busy), 32'h0);

        // Halt: further fetches and branches ignored
        fetch(32'hF000_0000, 0);
        chk("t6_halt", 32'(halted), 32'h1);
        chk("t6_vld", 32'(ir_valid), 32'h1);
        chk("t6_pc", 32'(pc_out), 32'h0043);
        chk("t6_op", 32'(opcode), 32'hF);
        fetch_req = 1'b1; pc_write = 1'b1;
        tick();
        fetch_req = 1'b0; pc_write = 1'b0;
        tick();
        chk("t6_noreq", 32'(bus.imem_req), 32'h0);
        chk("t6_frozen", 32'(pc_out), 32'h0043);
        chk("t6_still", 32'(halted), 32'h1);

        rst_f = 1'b1;
        tick();
        rst_f = 1'b0;
        chk_reset("rst_halt");

        // Reset aborting an in-flight fetch
        fetch(32'h4000_0007, 0);
        branch(1'b0);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("t7_req", 32'(bus.imem_req), 32'h1);
        chk("t7_addr", 32'(bus.imem_addr), 32'h0007);
        rst_f = 1'b1;
        tick();
        rst_f = 1'b0;
        chk_reset("rst_req");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
